// File: rtl/vga_pkg.sv
// Shared VGA framebuffer geometry, widths and rectangle-fill FSM states.
// Imported by the rectangle fill engine and its raster counter.
package vga_pkg;

  localparam int PIXEL_X_WIDTH = 10;
  localparam int PIXEL_Y_WIDTH = 9;
  localparam int PIXEL_X_MAX   = 640;
  localparam int PIXEL_Y_MAX   = 480;
  localparam int ADDR_WIDTH    = 19;
  localparam int COLOR_WIDTH   = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/rect_raster_counter.sv
// Raster walker: steps cur_x/cur_y across a rectangle and forms the address.
// Ports: load/step controls, rectangle bounds in, linear addr and last flag out.
module rect_raster_counter
  import vga_pkg::*;
#(
  parameter int XW   = PIXEL_X_WIDTH,
  parameter int YW   = PIXEL_Y_WIDTH,
  parameter int XMAX = PIXEL_X_MAX,
  parameter int AW   = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] x_start_in,
  input  logic [XW-1:0] x_end_in,
  input  logic [YW-1:0] y_start_in,
  input  logic [YW-1:0] y_end_in,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [XW-1:0] x_start;
  logic [XW-1:0] x_end;
  logic [YW-1:0] y_end;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [AW-1:0] row_base;

  // The only multiply is at load; rows then advance by addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_start  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
    end else if (load) begin
      x_start  <= x_start_in;
      x_end    <= x_end_in;
      y_end    <= y_end_in;
      cur_x    <= x_start_in;
      cur_y    <= y_start_in;
      row_base <= AW'(y_start_in) * AW'(XMAX);
    end else if (step && !last) begin
      if (cur_x < x_end) begin
        cur_x <= cur_x + XW'(1);
      end else begin
        cur_x    <= x_start;
        cur_y    <= cur_y + YW'(1);
        row_base <= row_base + AW'(XMAX);
      end
    end
  end

  assign addr = row_base + AW'(cur_x);
  assign last = (cur_x == x_end) && (cur_y == y_end);

endmodule

// File: rtl/spixel_rect_fill.sv
// Fills a clipped pixel rectangle with one colour, one framebuffer write per pixel.
// Ports: req valid/ready + corners/colour in, wr_en/ready/addr/data out, busy, done.
module spixel_rect_fill
  import vga_pkg::*;
#(
  parameter int PIXEL_X_WIDTH = vga_pkg::PIXEL_X_WIDTH,
  parameter int PIXEL_Y_WIDTH = vga_pkg::PIXEL_Y_WIDTH,
  parameter int PIXEL_X_MAX   = vga_pkg::PIXEL_X_MAX,
  parameter int PIXEL_Y_MAX   = vga_pkg::PIXEL_Y_MAX,
  parameter int ADDR_WIDTH    = vga_pkg::ADDR_WIDTH,
  parameter int COLOR_WIDTH   = vga_pkg::COLOR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [PIXEL_X_WIDTH-1:0] tlx,
  input  logic [PIXEL_Y_WIDTH-1:0] tly,
  input  logic [PIXEL_X_WIDTH-1:0] brx,
  input  logic [PIXEL_Y_WIDTH-1:0] bry,
  input  logic [COLOR_WIDTH-1:0]   color,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [COLOR_WIDTH-1:0]   wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [PIXEL_X_WIDTH-1:0] XLIM =
    PIXEL_X_WIDTH'(PIXEL_X_MAX - 1);
  localparam logic [PIXEL_Y_WIDTH-1:0] YLIM =
    PIXEL_Y_WIDTH'(PIXEL_Y_MAX - 1);

  fill_state_e state_q;

  logic [COLOR_WIDTH-1:0]   color_q;
  logic [PIXEL_X_WIDTH-1:0] brx_c;
  logic [PIXEL_Y_WIDTH-1:0] bry_c;
  logic [ADDR_WIDTH-1:0]    addr;
  logic                     accept;
  logic                     degen;
  logic                     xfer;
  logic                     last;

  assign brx_c  = (brx > XLIM) ? XLIM : brx;
  assign bry_c  = (bry > YLIM) ? YLIM : bry;
  assign degen  = (tlx > brx_c) || (tly > bry_c);
  assign accept = req_valid && req_ready;
  assign xfer   = (state_q == FILL) && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      color_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (degen) begin
              state_q <= DONE;
            end else begin
              state_q <= FILL;
              color_q <= color;
            end
          end
        end
        FILL: begin
          if (xfer && last) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  rect_raster_counter #(
    .XW   (PIXEL_X_WIDTH),
    .YW   (PIXEL_Y_WIDTH),
    .XMAX (PIXEL_X_MAX),
    .AW   (ADDR_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (accept && !degen),
    .step       (xfer),
    .x_start_in (tlx),
    .x_end_in   (brx_c),
    .y_start_in (tly),
    .y_end_in   (bry_c),
    .addr       (addr),
    .last       (last)
  );

  assign req_ready = !rst && (state_q == IDLE);
  assign wr_en     = (state_q == FILL);
  assign wr_addr   = wr_en ? addr : '0;
  assign wr_data   = wr_en ? color_q : '0;
  assign busy      = (state_q == FILL) || (state_q == DONE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_spixel_rect_fill.sv
// Directed bench for spixel_rect_fill: raster order, clipping, stalls, reset.
// Compares every beat against an independent raster model.
module tb_spixel_rect_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  tlx = '0;
  logic [8:0]  tly = '0;
  logic [9:0]  brx = '0;
  logic [8:0]  bry = '0;
  logic [11:0] color = '0;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;

  spixel_rect_fill dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .tlx       (tlx),
    .tly       (tly),
    .brx       (brx),
    .bry       (bry),
    .color     (color),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  int          exp_q[$];
  int          got_q[$];
  logic [11:0] exp_col;
  int beats, first_cyc, last_cyc, done_cyc, done_cnt, extra;
  bit mon_en = 1'b1;
  bit bp = 1'b0;

  initial begin
    done_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      wr_ready = bp ? ~wr_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (wr_en) begin
        if (exp_q.size() > 0) begin
          check("addr", wr_addr, exp_q[0]);
          check("data", wr_data, exp_col);
        end else begin
          extra++;
        end
        if (wr_ready) begin
          if (beats == 0) first_cyc = cyc;
          last_cyc = cyc;
          got_q.push_back(int'(wr_addr));
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beats++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic model(input int tx, ty, bx, by);
    int ex, ey;
    exp_q.delete();
    ex = (bx > 639) ? 639 : bx;
    ey = (by > 479) ? 479 : by;
    for (int y = ty; y <= ey; y++)
      for (int x = tx; x <= ex; x++)
        exp_q.push_back(y * 640 + x);
  endtask

  task automatic clear_mon();
    got_q.delete();
    beats = 0;
    extra = 0;
    first_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic send(input int tx, ty, bx, by,
                      input logic [11:0] col,
                      output int acc);
    @(negedge clk);
    tlx = tx[9:0];
    tly = ty[8:0];
    brx = bx[9:0];
    bry = by[8:0];
    color = col;
    req_valid = 1'b1;
    check("req_ready_at_req", req_ready, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tlx = '1;
    color = ~col;
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    int k = 0;
    while (done_cnt == start_cnt && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", done_cnt - start_cnt, 1);
  endtask

  int acc;

  task automatic run(input int tx, ty, bx, by,
                     input logic [11:0] col,
                     input int nb, input int lat);
    int s;
    model(tx, ty, bx, by);
    exp_col = col;
    clear_mon();
    s = done_cnt;
    send(tx, ty, bx, by, col, acc);
    wait_done(s, 500);
    @(negedge clk);
    check("req_ready_after", req_ready, 1);
    check("busy_after", busy, 0);
    check("beats", beats, nb);
    check("extra", extra, 0);
    check("left", exp_q.size(), 0);
    if (lat >= 0) check("done_lat", done_cyc - acc, lat);
    if (nb > 0) check("first_lat", first_cyc - acc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    run(30, 20, 39, 29, 12'hF00, 100, 101);
    if (got_q.size() == 100) begin
      check("n_addr0", got_q[0], 12830);
      check("n_addr9", got_q[9], 12839);
      check("n_addr10", got_q[10], 13470);
      check("n_addr99", got_q[99], 18599);
    end

    bp = 1'b1;
    run(30, 20, 39, 29, 12'h0A5, 100, -1);
    check("bp_done_after_last", done_cyc - last_cyc, 1);
    bp = 1'b0;
    @(posedge clk);

    run(630, 470, 639, 479, 12'h123, 100, 101);
    if (got_q.size() == 100) begin
      check("c_addr0", got_q[0], 301430);
      check("c_addr99", got_q[99], 307199);
    end

    run(635, 0, 644, 0, 12'h456, 5, 6);
    if (got_q.size() == 5) begin
      check("clip_addr0", got_q[0], 635);
      check("clip_addr4", got_q[4], 639);
    end

    run(40, 0, 39, 0, 12'h789, 0, 1);

    begin
      int s;
      model(0, 0, 1, 1);
      exp_col = 12'hABC;
      clear_mon();
      s = done_cnt;
      send(0, 0, 1, 1, 12'hABC, acc);
      @(negedge clk);
      tlx = 10'd5; tly = 9'd5; brx = 10'd5; bry = 9'd5;
      color = 12'h111;
      req_valid = 1'b1;
      check("busy_req_ready", req_ready, 0);
      check("busy_flag", busy, 1);
      @(negedge clk);
      check("busy_req_ready2", req_ready, 0);
      req_valid = 1'b0;
      wait_done(s, 100);
      repeat (3) @(negedge clk);
      check("busy_beats", beats, 4);
      check("busy_extra", extra, 0);
      check("busy_done_cnt", done_cnt - s, 1);
    end
    run(5, 5, 5, 5, 12'h111, 1, 2);
    if (got_q.size() == 1) check("second_addr", got_q[0], 3205);

    begin
      int s;
      model(30, 20, 39, 29);
      exp_col = 12'h0F0;
      clear_mon();
      s = done_cnt;
      send(30, 20, 39, 29, 12'h0F0, acc);
      repeat (37) @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst = 1'b1;
      check("rst_mid_beats", beats, 37);
      @(negedge clk);
      check("rst_mid_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_mid_wr_en", wr_en, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ready", req_ready, 1);
      repeat (3) @(negedge clk);
      check("rst_mid_no_done", done_cnt - s, 0);
      check("rst_mid_no_wr", beats, 37);
    end
    run(100, 200, 102, 200, 12'h3C3, 3, 4);
    if (got_q.size() == 3) begin
      check("post_rst_addr0", got_q[0], 128100);
      check("post_rst_addr2", got_q[2], 128102);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
